// File: rtl/cmac_core_cfg_seq.sv
// cmac_core_cfg_seq: in-order multi-group configuration sequencer for the CMAC core.
// Serves NUM_GRP ping-pong register groups. For each layer it issues a one-cycle
// load strobe and latches that group's conv mode. It tracks the layer until done,
// then enforces a settle gap before the next layer can start.
module cmac_core_cfg_seq #(
    parameter int unsigned NUM_GRP = 2,
    parameter int unsigned MODE_W  = 2,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned SETTLE  = 2
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    input  logic [NUM_GRP-1:0]          reg2dp_op_en,
    input  logic [NUM_GRP*MODE_W-1:0]   reg2dp_conv_mode,
    input  logic                        dp2reg_done,
    output logic                        cfg_reg_en,
    output logic [$clog2(NUM_GRP)-1:0]  cfg_grp_id,
    output logic [MODE_W-1:0]           cfg_conv_mode,
    output logic                        cfg_is_wg,
    output logic                        cfg_busy,
    output logic [CNT_W-1:0]            dp2reg_layer_cnt,
    output logic                        cfg_err
);

    localparam int unsigned GRP_W = $clog2(NUM_GRP);
    localparam int unsigned SET_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_GRP-1:0]   op_en_d1;
    logic                 done_d1;
    logic [SET_W-1:0]     settle_cnt;
    logic [SET_W-1:0]     settle_nxt;
    logic                 reg_en_nxt;
    logic [GRP_W-1:0]     grp_nxt;
    logic [MODE_W-1:0]    mode_nxt;
    logic                 wg_nxt;
    logic                 busy_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 err_nxt;
    logic [MODE_W-1:0]    mode_sel;

    // Pick the conv-mode field of the group currently being served (undelayed input).
    always_comb begin
        mode_sel = '0;
        for (int g = 0; g < int'(NUM_GRP); g++) begin
            if (cfg_grp_id == GRP_W'(g)) begin
                mode_sel = reg2dp_conv_mode[g*MODE_W +: MODE_W];
            end
        end
    end

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        reg_en_nxt = 1'b0;
        grp_nxt    = cfg_grp_id;
        mode_nxt   = cfg_conv_mode;
        wg_nxt     = cfg_is_wg;
        cnt_nxt    = dp2reg_layer_cnt;
        // A done outside RUN is a protocol error; the flag is sticky until reset.
        err_nxt    = cfg_err | (done_d1 && (state != ST_RUN));

        case (state)
            ST_IDLE: begin
                if (op_en_d1[cfg_grp_id]) begin
                    state_nxt  = ST_START;
                    reg_en_nxt = 1'b1;
                    mode_nxt   = mode_sel;
                    wg_nxt     = (mode_sel == MODE_W'(1));
                end
            end
            ST_START: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (done_d1) begin
                    cnt_nxt    = dp2reg_layer_cnt + CNT_W'(1);
                    grp_nxt    = cfg_grp_id + GRP_W'(1);
                    settle_nxt = SET_W'(SETTLE);
                    state_nxt  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt <= SET_W'(1)) begin
                    settle_nxt = '0;
                    state_nxt  = ST_IDLE;
                end else begin
                    settle_nxt = settle_cnt - SET_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State, input-delay and output registers with synchronous active-low reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state            <= ST_IDLE;
            op_en_d1         <= '0;
            done_d1          <= 1'b0;
            settle_cnt       <= '0;
            cfg_reg_en       <= 1'b0;
            cfg_grp_id       <= '0;
            cfg_conv_mode    <= '0;
            cfg_is_wg        <= 1'b0;
            cfg_busy         <= 1'b0;
            dp2reg_layer_cnt <= '0;
            cfg_err          <= 1'b0;
        end else begin
            state            <= state_nxt;
            op_en_d1         <= reg2dp_op_en;
            done_d1          <= dp2reg_done;
            settle_cnt       <= settle_nxt;
            cfg_reg_en       <= reg_en_nxt;
            cfg_grp_id       <= grp_nxt;
            cfg_conv_mode    <= mode_nxt;
            cfg_is_wg        <= wg_nxt;
            cfg_busy         <= busy_nxt;
            dp2reg_layer_cnt <= cnt_nxt;
            cfg_err          <= err_nxt;
        end
    end

endmodule
